// File: rtl/rvj1_data_mem_responder.sv
// Data-port memory responder for the rvj1 LSU: one outstanding request, fixed latency,
// byte-lane RAM at BASE_ADDR with access-fault / illegal byte-enable reporting.
module rvj1_data_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            we_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic [3:0]      be_reg;
  logic            err_reg;
  logic            rdata_en_reg;

  logic            be_ok;
  logic            addr_ok;
  logic            req_err;
  logic            accept;
  logic            enter_resp_idle;
  logic            enter_resp_wait;
  logic            ram_en;
  logic            acc_we;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;

  // Only naturally aligned byte, half-word and word lane patterns are legal.
  always_comb begin
    be_ok = 1'b0;
    case (req_be_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  assign addr_ok = ({1'b0, req_addr_i} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, req_addr_i} <  END_ADDR) &&
                   (req_addr_i[1:0] == 2'b00);
  assign req_err = !(addr_ok && be_ok);

  assign accept          = (state_reg == ST_IDLE) && req_valid_i;
  assign enter_resp_idle = accept && NO_WAIT;
  assign enter_resp_wait = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
  assign ram_en          = (enter_resp_idle || enter_resp_wait) && !rst_i;

  // With zero wait the RAM is accessed on the accept edge, straight from the request bus.
  assign acc_we    = enter_resp_idle ? req_we_i               : we_reg;
  assign acc_err   = enter_resp_idle ? req_err                : err_reg;
  assign acc_idx   = enter_resp_idle ? req_addr_i[AW+1:2]     : idx_reg;
  assign acc_wdata = enter_resp_idle ? req_wdata_i            : wdata_reg;
  assign acc_be    = enter_resp_idle ? req_be_i               : be_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];
    logic [7:0] lane_q;

    always_ff @(posedge clk_i) begin
      if (ram_en) begin
        if (acc_we && !acc_err && acc_be[gi]) begin
          lane_mem[acc_idx] <= acc_wdata[gi*8 +: 8];
        end
        lane_q <= lane_mem[acc_idx];
      end
    end

    assign rsp_rdata_o[gi*8 +: 8] = rdata_en_reg ? lane_q : 8'h00;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      we_reg       <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= 32'h0;
      be_reg       <= 4'h0;
      err_reg      <= 1'b0;
      rdata_en_reg <= 1'b0;
      req_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_reg      <= req_we_i;
            idx_reg     <= req_addr_i[AW+1:2];
            wdata_reg   <= req_wdata_i;
            be_reg      <= req_be_i;
            err_reg     <= req_err;
            req_ready_o <= 1'b0;
            if (NO_WAIT) begin
              state_reg    <= ST_RESP;
              rsp_valid_o  <= 1'b1;
              rsp_err_o    <= req_err;
              rdata_en_reg <= !req_we_i && !req_err;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg    <= ST_RESP;
            rsp_valid_o  <= 1'b1;
            rsp_err_o    <= err_reg;
            rdata_en_reg <= !we_reg && !err_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_reg    <= ST_IDLE;
            rsp_valid_o  <= 1'b0;
            rsp_err_o    <= 1'b0;
            rdata_en_reg <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvj1_data_mem_responder.sv
// Scoreboard bench for rvj1_data_mem_responder: directed + random traffic against a
// word-array reference model, plus latency/throughput sweeps over WAIT_CYCLES.
`timescale 1ns/1ps
module tb_rvj1_data_mem_responder;

  localparam int unsigned MW   = 64;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned W    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  rvj1_data_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_edge;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [MW];
  int          last_hs_edge = 0;
  int          last_acc_edge = 0;
  bit          rand_bp = 0;
  bit          sweep_done [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [31:0] addr, input logic [3:0] be);
    longint a  = {32'd0, addr};
    longint lo = {32'd0, BASE};
    longint hi = lo + 4 * MW;
    bit be_ok = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
                (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
    return (a >= lo) && (a < hi) && (a % 4 == 0) && be_ok;
  endfunction

  // Reference: a plain word array updated byte by byte in request order.
  task automatic model_apply(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output exp_t e);
    int idx;
    e.rdata = 32'h0;
    e.err = 1'b1;
    e.acc_edge = 0;
    if (legal(addr, be)) begin
      idx = int'((addr - BASE) / 4);
      e.err = 1'b0;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end else begin
        e.rdata = model[idx];
      end
    end
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    exp_t e;
    int n = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end else begin
      model_apply(we, addr, wdata, be, e);
      e.acc_edge = cyc + 1;
      chk("accept_after_handshake", 32'(e.acc_edge > last_hs_edge), 32'd1);
      last_acc_edge = e.acc_edge;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || rsp_valid) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: new responses are compared against the scoreboard head; held ones for stability.
  bit          in_resp = 0;
  logic [31:0] held_rdata;
  logic        held_err;
  always @(negedge clk) begin
    if (rst) begin
      in_resp = 0;
    end else if (rsp_valid) begin
      if (!in_resp) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: rdata=%h err=%b required no response", rsp_rdata, rsp_err);
        end else begin
          chk("rsp_rdata", rsp_rdata, sb[0].rdata);
          chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
          chk("rsp_latency", 32'((cyc + 1) - sb[0].acc_edge), 32'(W + 1));
          $display("rsp: rdata=%h err=%b expected rdata=%h err=%b", rsp_rdata, rsp_err,
                   sb[0].rdata, sb[0].err);
        end
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        in_resp    = 1;
      end else begin
        chk("hold_rdata", rsp_rdata, held_rdata);
        chk("hold_err", 32'(rsp_err), 32'(held_err));
      end
      chk("req_ready_low_in_resp", 32'(req_ready), 32'd0);
      if (rsp_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        last_hs_edge = cyc + 1;
        in_resp = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Throughput / latency sweep: back-to-back stores on dedicated instances.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int unsigned SW = (gi == 0) ? 0 : (gi == 1) ? 1 : 7;
    logic        s_valid, s_ready, s_rvalid, s_err;
    logic [31:0] s_rdata;

    rvj1_data_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(BASE), .WAIT_CYCLES(SW)) u_sw (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(s_valid), .req_ready_o(s_ready), .req_we_i(1'b1),
      .req_addr_i(BASE + 32'h8), .req_wdata_i(32'h1234_5678), .req_be_i(4'hF),
      .rsp_valid_o(s_rvalid), .rsp_ready_i(1'b1),
      .rsp_rdata_o(s_rdata), .rsp_err_o(s_err)
    );

    initial begin
      int acc_prev = -1;
      int n = 0;
      s_valid = 1'b0;
      sweep_done[gi] = 0;
      wait (rst == 1'b0);
      @(posedge clk); #1;
      s_valid = 1'b1;
      for (int k = 0; k < 100 && n < 6; k++) begin
        @(negedge clk);
        if (s_rvalid) begin
          chk("sweep_latency", 32'((cyc + 1) - acc_prev), 32'(SW + 1));
          chk("sweep_store_rsp", {s_rdata[31:1], s_err}, 32'h0);
          $display("sweep W=%0d rsp: rdata=%h err=%b", SW, s_rdata, s_err);
        end
        if (s_ready) begin
          if (acc_prev >= 0) chk("sweep_interval", 32'((cyc + 1) - acc_prev), 32'(SW + 2));
          acc_prev = cyc + 1;
          n++;
        end
      end
      if (n < 6) begin
        checks++; failures++;
        $display("FAIL sweep_accepts: got %0d required 6 (W=%0d)", n, SW);
      end
      s_valid = 1'b0;
      sweep_done[gi] = 1;
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  lbe [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [31:0] addr;
    logic [3:0]  be;
    int          n;

    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 1;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < MW; i++) issue(1, BASE + 32'(4 * i), $urandom, 4'hF);

    issue(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
    issue(0, 32'h8000_0010, 32'h0, 4'b1111);
    issue(1, 32'h8000_0020, 32'h1122_3344, 4'b1111);
    issue(1, 32'h8000_0020, 32'h0000_AB00, 4'b0010);
    issue(0, 32'h8000_0020, 32'h0, 4'b1111);
    issue(1, 32'h8000_0020, 32'h5566_0000, 4'b1100);
    issue(0, 32'h8000_0020, 32'h0, 4'b1111);

    issue(0, 32'h7FFF_FFFC, 32'h0, 4'b1111);
    issue(0, BASE + 32'(4 * MW), 32'h0, 4'b1111);
    issue(0, 32'h8000_0002, 32'h0, 4'b1111);
    issue(0, 32'h8000_0020, 32'h0, 4'b0110);
    issue(0, 32'h8000_0020, 32'h0, 4'b0000);
    issue(1, 32'h8000_0022, 32'hFFFF_FFFF, 4'b1111);
    issue(1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0110);
    issue(1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000);
    issue(1, BASE + 32'(4 * MW), 32'hFFFF_FFFF, 4'b1111);
    issue(0, 32'h8000_0020, 32'h0, 4'b1111);
    drain();

    // Backpressure: response held 5 cycles while a second request waits.
    rsp_ready = 0;
    fork
      begin
        issue(0, 32'h8000_0010, 32'h0, 4'b1111);
        issue(0, 32'h8000_0020, 32'h0, 4'b1111);
        chk("accept_cycle_after_handshake", 32'(last_acc_edge), 32'(last_hs_edge + 1));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin n++; @(negedge clk); end
        chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1;
      end
    join
    drain();

    rand_bp = 1;
    repeat (200) begin
      n = $urandom_range(0, 9);
      addr = BASE + 32'(4 * $urandom_range(0, MW - 1));
      be = lbe[$urandom_range(0, 6)];
      if (n == 7) addr = $urandom;
      else if (n == 8) addr = addr + 32'($urandom_range(1, 3));
      else if (n == 9) be = 4'($urandom_range(0, 15));
      issue($urandom_range(0, 1) == 1, addr, $urandom, be);
    end
    rand_bp = 0;
    @(posedge clk); #1;
    rsp_ready = 1;
    drain();

    n = 0;
    while (!(sweep_done[0] && sweep_done[1] && sweep_done[2]) && n < 2000) begin
      n++;
      @(posedge clk);
    end
    chk("sweep_complete", 32'(sweep_done[0] && sweep_done[1] && sweep_done[2]), 32'd1);
    @(posedge clk); #1;

    // Reset while a store sits in WAIT: it must be dropped and never written.
    req_we = 1; req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    req_valid = 1;
    @(negedge clk);
    chk("rst_test_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    #1 rst = 1;
    #1;
    chk("async_rst_req_ready", 32'(req_ready), 32'd1);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("async_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    issue(0, 32'h8000_0020, 32'h0, 4'b1111);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
